// File: rtl/spi_master_cs_if.sv
// rtl/spi_master_cs_if.sv - byte-side and serial-side signal bundle for spi_master_cs
//
// Purpose: groups the fabric byte handshake and the SPI pins of spi_master_cs.
// Signals:
//   i_TX_Count  byte count for the transaction (sampled on the first byte only)
//   i_TX_Byte   byte to send, MSb first
//   i_TX_DV     one-cycle transmit strobe, honoured only while o_TX_Ready=1
//   o_TX_Ready  master can take the next byte
//   o_RX_Count  0-based index of the received byte within the transaction
//   o_RX_DV     one-cycle pulse qualifying o_RX_Byte / o_RX_Count
//   o_RX_Byte   byte captured from MISO
//   o_SPI_Clk   SCLK
//   i_SPI_MISO  serial data from the slave
//   o_SPI_MOSI  serial data to the slave
//   o_SPI_CS_n  chip select, active low
// Modports: master = the SPI master block, slave = the fabric/peripheral side.
interface spi_master_cs_if #(
  parameter int MAX_BYTES_PER_CS = 2
);
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);

  logic [CW-1:0] i_TX_Count;
  logic [7:0]    i_TX_Byte;
  logic          i_TX_DV;
  logic          o_TX_Ready;
  logic [CW-1:0] o_RX_Count;
  logic          o_RX_DV;
  logic [7:0]    o_RX_Byte;
  logic          o_SPI_Clk;
  logic          i_SPI_MISO;
  logic          o_SPI_MOSI;
  logic          o_SPI_CS_n;

  modport master (
    input  i_TX_Count, i_TX_Byte, i_TX_DV, i_SPI_MISO,
    output o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte,
           o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
  );

  modport slave (
    output i_TX_Count, i_TX_Byte, i_TX_DV, i_SPI_MISO,
    input  o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte,
           o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
  );
endinterface

// File: rtl/spi_master_cs.sv
// rtl/spi_master_cs.sv - SPI master with chip select held across multi-byte transactions
//
// Purpose: serialises fabric bytes onto MOSI, deserialises MISO, derives SCLK from
// w_SPI_Clk and keeps CS_n low for up to MAX_BYTES_PER_CS bytes per transaction.
// Ports:
//   w_SPI_Clk  system clock (only clock in the block)
//   i_Rst_L    asynchronous active-low reset
//   bus        spi_master_cs_if.master: byte handshake plus SPI pins
module spi_master_cs #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int MAX_BYTES_PER_CS  = 2,
  parameter int CS_INACTIVE_CLKS  = 1
) (
  input  logic             w_SPI_Clk,
  input  logic             i_Rst_L,
  spi_master_cs_if.master  bus
);
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int KW = $clog2(CLKS_PER_HALF_BIT + 1);
  localparam int HW = $clog2(CS_INACTIVE_CLKS + 2);
  localparam logic CPOL = 1'(SPI_MODE / 2);
  localparam logic CPHA = 1'(SPI_MODE);
  // edge_cnt value (edge number minus one) of the eighth MISO sample
  localparam logic [3:0] LAST_SAMPLE = CPHA ? 4'd15 : 4'd14;

  typedef enum logic [1:0] {IDLE, XFER, WAIT_NEXT, CS_HOLD} state_t;
  state_t state_q, state_d;

  logic [KW-1:0] clk_cnt;
  logic [3:0]    edge_cnt;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] byte_total, byte_idx, count_sat;
  logic [7:0]    tx_byte_q, rx_shift;
  logic [2:0]    bit_sel;
  logic          tx_ready_d;
  logic          accept, edge_tick, byte_end, last_byte, leading;
  logic          do_sample, do_shift, hold_done;

  always_comb begin
    accept    = bus.o_TX_Ready && bus.i_TX_DV && (state_q == IDLE || state_q == WAIT_NEXT);
    edge_tick = (state_q == XFER) && (clk_cnt == KW'(CLKS_PER_HALF_BIT - 1));
    byte_end  = edge_tick && (edge_cnt == 4'd15);
    last_byte = (byte_idx == byte_total - CW'(1));
    // edge_cnt holds the number of edges already issued, so even values are leading edges
    leading   = ~edge_cnt[0];
    do_sample = edge_tick && (leading ^ CPHA);
    // CPHA=0 has no MOSI update on the final trailing edge; the next byte loads bit7 on accept
    do_shift  = edge_tick && (leading == CPHA) && !(!CPHA && edge_cnt == 4'd15);
    bit_sel   = 3'd7 - edge_cnt[3:1] - {2'b00, ~CPHA};
    hold_done = (state_q == CS_HOLD) && (int'(hold_cnt) + 1 >= CS_INACTIVE_CLKS);

    if (bus.i_TX_Count == '0)
      count_sat = CW'(1);
    else if (bus.i_TX_Count > CW'(MAX_BYTES_PER_CS))
      count_sat = CW'(MAX_BYTES_PER_CS);
    else
      count_sat = bus.i_TX_Count;
  end

  always_comb begin
    state_d    = state_q;
    tx_ready_d = bus.o_TX_Ready;
    case (state_q)
      IDLE: begin
        tx_ready_d = 1'b1;
        if (accept) begin
          state_d    = XFER;
          tx_ready_d = 1'b0;
        end
      end
      XFER: begin
        if (byte_end) begin
          if (last_byte) begin
            state_d = CS_HOLD;
          end else begin
            state_d    = WAIT_NEXT;
            tx_ready_d = 1'b1;
          end
        end
      end
      WAIT_NEXT: begin
        if (accept) begin
          state_d    = XFER;
          tx_ready_d = 1'b0;
        end
      end
      CS_HOLD: begin
        if (hold_done) begin
          state_d    = IDLE;
          tx_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bus.o_SPI_CS_n <= 1'b1;
      bus.o_SPI_Clk  <= CPOL;
      bus.o_SPI_MOSI <= 1'b0;
      bus.o_TX_Ready <= 1'b0;
      bus.o_RX_DV    <= 1'b0;
      bus.o_RX_Byte  <= 8'h00;
      bus.o_RX_Count <= '0;
      clk_cnt        <= '0;
      edge_cnt       <= 4'd0;
      hold_cnt       <= '0;
      byte_total     <= CW'(1);
      byte_idx       <= '0;
      tx_byte_q      <= 8'h00;
      rx_shift       <= 8'h00;
    end else begin
      bus.o_TX_Ready <= tx_ready_d;
      bus.o_RX_DV    <= 1'b0;

      if (accept) begin
        tx_byte_q      <= bus.i_TX_Byte;
        clk_cnt        <= '0;
        edge_cnt       <= 4'd0;
        bus.o_SPI_CS_n <= 1'b0;
        if (!CPHA) bus.o_SPI_MOSI <= bus.i_TX_Byte[7];
        if (state_q == IDLE) begin
          byte_total <= count_sat;
          byte_idx   <= '0;
        end
      end

      if (state_q == XFER) begin
        if (edge_tick) begin
          clk_cnt       <= '0;
          edge_cnt      <= edge_cnt + 4'd1;
          bus.o_SPI_Clk <= ~bus.o_SPI_Clk;
        end else begin
          clk_cnt <= clk_cnt + KW'(1);
        end
        if (do_shift) bus.o_SPI_MOSI <= tx_byte_q[bit_sel];
        if (do_sample) begin
          rx_shift <= {rx_shift[6:0], bus.i_SPI_MISO};
          if (edge_cnt == LAST_SAMPLE) begin
            bus.o_RX_DV    <= 1'b1;
            bus.o_RX_Byte  <= {rx_shift[6:0], bus.i_SPI_MISO};
            bus.o_RX_Count <= byte_idx;
          end
        end
        if (byte_end) begin
          if (last_byte) begin
            bus.o_SPI_CS_n <= 1'b1;
            hold_cnt       <= '0;
          end else begin
            byte_idx <= byte_idx + CW'(1);
          end
        end
      end

      if (state_q == CS_HOLD) hold_cnt <= hold_cnt + HW'(1);
    end
  end
endmodule

// File: tb/tb_spi_master_cs.sv
// tb/tb_spi_master_cs.sv - randomized scoreboard bench for spi_master_cs in all four SPI modes
module tb_spi_master_cs;
  localparam int CPHB = 2;
  localparam int MAXB = 2;
  localparam int CSI  = 1;
  localparam int CW   = $clog2(MAXB + 1);
  localparam logic [3:0] IDLE_SCLK = 4'b1100;

  logic          clk;
  logic          rst_l;
  logic [CW-1:0] tx_count;
  logic [7:0]    tx_byte;
  logic          tx_dv;
  logic [3:0]    ready_v, cs_v, sclk_v, mosi_v, rx_dv_v;
  int            n_checks, n_fail;

  logic [7:0]    slv_tx_q   [4][$];
  logic [7:0]    exp_mosi_q [4][$];
  logic [CW+7:0] exp_rx_q   [4][$];
  int            exp_len_q  [4][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam logic CPOL = (m >= 2);
    localparam logic CPHA = ((m % 2) == 1);

    spi_master_cs_if #(.MAX_BYTES_PER_CS(MAXB)) bus ();
    logic miso = 1'b0;

    spi_master_cs #(
      .SPI_MODE(m), .CLKS_PER_HALF_BIT(CPHB),
      .MAX_BYTES_PER_CS(MAXB), .CS_INACTIVE_CLKS(CSI)
    ) dut (
      .w_SPI_Clk(clk), .i_Rst_L(rst_l), .bus(bus)
    );

    assign bus.i_TX_Count = tx_count;
    assign bus.i_TX_Byte  = tx_byte;
    assign bus.i_TX_DV    = tx_dv;
    assign bus.i_SPI_MISO = miso;
    assign ready_v[m]     = bus.o_TX_Ready;
    assign cs_v[m]        = bus.o_SPI_CS_n;
    assign sclk_v[m]      = bus.o_SPI_Clk;
    assign mosi_v[m]      = bus.o_SPI_MOSI;
    assign rx_dv_v[m]     = bus.o_RX_DV;

    // behavioural SPI slave plus RX monitor for this mode
    int lc = 0, s_edges = 0, nbytes = 0, cur_len = 0, last_evt = 0, hi_cnt = 0, samp_cyc = -1;
    logic prev_cs = 1'b1, prev_sclk = CPOL, prev_dv = 1'b0, had_txn = 1'b0, lead;
    logic [7:0] sh_out = 8'h00, sh_in = 8'h00;
    logic [CW+7:0] e;

    task automatic load_next();
      if (slv_tx_q[m].size() == 0) begin
        check($sformatf("slave_data_m%0d", m), 1, 0);
        sh_out = 8'h00;
      end else begin
        sh_out = slv_tx_q[m].pop_front();
      end
      if (!CPHA) begin
        miso   = sh_out[7];
        sh_out = sh_out << 1;
      end
    endtask

    always @(negedge clk) begin
      lc++;
      if (!rst_l) begin
        prev_cs = 1'b1; prev_sclk = CPOL; prev_dv = 1'b0; had_txn = 1'b0;
        s_edges = 0; nbytes = 0; cur_len = 0; hi_cnt = 0; miso = 1'b0; samp_cyc = -1;
      end else begin
        if (!prev_cs && bus.o_SPI_Clk != prev_sclk) begin
          if (!(s_edges == 0 && nbytes > 0))
            check($sformatf("edge_gap_m%0d", m), lc - last_evt, CPHB);
          last_evt = lc;
          s_edges++;
          lead = (s_edges % 2 == 1);
          if (s_edges < 16) check($sformatf("ready_mid_byte_m%0d", m), bus.o_TX_Ready, 0);
          if (lead != CPHA) begin
            sh_in = {sh_in[6:0], bus.o_SPI_MOSI};
            if (s_edges == (CPHA ? 16 : 15)) samp_cyc = lc;
          end else if (s_edges < 16) begin
            miso   = sh_out[7];
            sh_out = sh_out << 1;
          end
          if (s_edges == 16) begin
            if (exp_mosi_q[m].size() == 0) check($sformatf("unexpected_mosi_m%0d", m), 1, 0);
            else check($sformatf("mosi_byte_m%0d", m), sh_in, exp_mosi_q[m].pop_front());
            nbytes++;
            s_edges = 0;
            if (nbytes < cur_len) load_next();
          end
        end
        if (prev_cs && !bus.o_SPI_CS_n) begin
          if (had_txn) check($sformatf("cs_gap_m%0d", m), hi_cnt >= CSI, 1);
          check($sformatf("sclk_idle_at_cs_m%0d", m), bus.o_SPI_Clk, CPOL);
          if (exp_len_q[m].size() == 0) begin
            check($sformatf("unexpected_cs_m%0d", m), 1, 0);
            cur_len = 0;
          end else begin
            cur_len = exp_len_q[m].pop_front();
          end
          nbytes = 0; s_edges = 0; last_evt = lc;
          load_next();
        end
        if (!prev_cs && bus.o_SPI_CS_n) begin
          check($sformatf("bytes_per_cs_m%0d", m), nbytes, cur_len);
          had_txn = 1'b1;
          hi_cnt  = 0;
        end
        if (bus.o_SPI_CS_n) hi_cnt++;

        if (bus.o_RX_DV) begin
          check($sformatf("rx_dv_width_m%0d", m), prev_dv, 0);
          check($sformatf("rx_dv_timing_m%0d", m), lc, samp_cyc);
          if (exp_rx_q[m].size() == 0) begin
            check($sformatf("unexpected_rx_m%0d", m), 1, 0);
          end else begin
            e = exp_rx_q[m].pop_front();
            check($sformatf("rx_byte_m%0d", m), bus.o_RX_Byte, e[7:0]);
            check($sformatf("rx_count_m%0d", m), bus.o_RX_Count, e[CW+7:8]);
          end
        end
        prev_dv   = bus.o_RX_DV;
        prev_cs   = bus.o_SPI_CS_n;
        prev_sclk = bus.o_SPI_Clk;
      end
    end
  end

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < 4; k++)
      s += slv_tx_q[k].size() + exp_mosi_q[k].size() + exp_rx_q[k].size() + exp_len_q[k].size();
    return s;
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (ready_v != 4'hF && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("ready_timeout", t < 2000, 1);
  endtask

  task automatic drain();
    int t = 0;
    while (t < 3000 && (pending() != 0 || ready_v != 4'hF || cs_v != 4'hF)) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", t < 3000, 1);
  endtask

  task automatic issue(input logic [7:0] b, input logic [CW-1:0] c);
    tx_byte  = b;
    tx_count = c;
    tx_dv    = 1'b1;
    @(negedge clk);
    tx_dv = 1'b0;
    check("ready_drop", ready_v, 4'h0);
  endtask

  task automatic do_txn(input int cnt_req, input int gap, input bit ign);
    int n;
    logic [7:0] mb[MAXB];
    logic [7:0] sb[MAXB];
    n = (cnt_req == 0) ? 1 : ((cnt_req > MAXB) ? MAXB : cnt_req);
    for (int i = 0; i < n; i++) begin
      mb[i] = 8'($urandom);
      sb[i] = 8'($urandom);
    end
    for (int k = 0; k < 4; k++) begin
      exp_len_q[k].push_back(n);
      for (int i = 0; i < n; i++) begin
        slv_tx_q[k].push_back(sb[i]);
        exp_mosi_q[k].push_back(mb[i]);
        exp_rx_q[k].push_back({CW'(i), sb[i]});
      end
    end
    for (int i = 0; i < n; i++) begin
      wait_ready();
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          check("cs_low_wait", cs_v, 4'h0);
          check("sclk_idle_wait", sclk_v, IDLE_SCLK);
          @(negedge clk);
        end
      end
      issue(mb[i], (i == 0) ? CW'(cnt_req) : CW'($urandom));
      if (ign) begin
        repeat (4) @(negedge clk);
        tx_byte  = ~mb[i];
        tx_count = CW'($urandom);
        tx_dv    = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int t;
    n_checks = 0; n_fail = 0;
    tx_dv = 1'b0; tx_byte = 8'h00; tx_count = '0;
    rst_l = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", cs_v, 4'hF);
    check("rst_sclk", sclk_v, IDLE_SCLK);
    check("rst_mosi", mosi_v, 4'h0);
    check("rst_ready", ready_v, 4'h0);
    check("rst_rx_dv", rx_dv_v, 4'h0);
    check("rst_rx_byte", g_mode[0].bus.o_RX_Byte, 8'h00);
    check("rst_rx_count", g_mode[3].bus.o_RX_Count, 0);
    #2 rst_l = 1'b1;
    check("ready_before_clk", ready_v, 4'h0);
    @(negedge clk);
    check("ready_after_reset", ready_v, 4'hF);

    do_txn(1, 0, 1'b0);
    do_txn(2, 0, 1'b0);
    do_txn(2, 50, 1'b0);
    do_txn(0, 0, 1'b0);
    do_txn(3, 3, 1'b0);
    do_txn(1, 0, 1'b1);
    do_txn(2, 0, 1'b1);
    drain();

    // reset in the middle of a byte
    do_txn(1, 0, 1'b0);
    t = 0;
    while (g_mode[0].s_edges != 7 && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("edge7_timeout", t < 500, 1);
    #1 rst_l = 1'b0;
    #1;
    check("midrst_cs", cs_v, 4'hF);
    check("midrst_sclk", sclk_v, IDLE_SCLK);
    check("midrst_mosi", mosi_v, 4'h0);
    check("midrst_ready", ready_v, 4'h0);
    check("midrst_rx_dv", rx_dv_v, 4'h0);
    check("midrst_rx_byte", g_mode[1].bus.o_RX_Byte, 8'h00);
    check("midrst_rx_count", g_mode[2].bus.o_RX_Count, 0);
    for (int k = 0; k < 4; k++) begin
      slv_tx_q[k].delete();
      exp_mosi_q[k].delete();
      exp_rx_q[k].delete();
      exp_len_q[k].delete();
    end
    repeat (3) @(negedge clk);
    #2 rst_l = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", ready_v, 4'hF);

    for (int r = 0; r < 25; r++)
      do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    drain();
    check("queues_empty", pending(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
